// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit.
//   op_e    : operation encodings presented on the op port
//   state_e : control FSM states
//   is_signed / is_div : operation classification helpers
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_signed(input op_e o);
    return (o == MULT) || (o == DIV);
  endfunction

  function automatic logic is_div(input op_e o);
    return (o == DIV) || (o == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iteration datapath: one result bit per step.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : initialise accumulator/operand from op_a/op_b, clear counter
//   step      : perform one shift-add (multiply) or restoring-divide step
//   div_mode  : operation class captured on load (1 = divide)
//   op_a/op_b : unsigned magnitudes (multiplicand/dividend, multiplier/divisor)
//   result    : multiply -> product; divide -> {remainder, quotient}
//   count     : steps performed since load, saturating at WIDTH
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               div_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned AW = 2 * WIDTH + 1;

  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_n;
  logic [AW-1:0]    shl;
  logic [WIDTH-1:0] opnd_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   psum;
  logic [WIDTH:0]   trial;

  // Multiply: conditional add into the upper half, then shift the whole
  // accumulator right. Divide: shift left, keep the trial subtraction when
  // the partial remainder covers the divisor and shift in a quotient 1.
  always_comb begin
    upper = acc_q[AW-1:WIDTH];
    psum  = acc_q[0] ? upper + {1'b0, opnd_q} : upper;
    shl   = {acc_q[AW-2:0], 1'b0};
    trial = shl[AW-1:WIDTH] - {1'b0, opnd_q};
    if (mode_q) begin
      acc_n = (shl[AW-1:WIDTH] >= {1'b0, opnd_q}) ? {trial, shl[WIDTH-1:1], 1'b1} : shl;
    end else begin
      acc_n = {1'b0, psum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= {{(WIDTH + 1){1'b0}}, (div_mode ? op_a : op_b)};
      opnd_q <= div_mode ? op_b : op_a;
      mode_q <= div_mode;
      cnt_q  <= '0;
    end else if (step) begin
      acc_q <= acc_n;
      if (cnt_q != CNT_W'(WIDTH)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign result = acc_q[2*WIDTH-1:0];
  assign count  = cnt_q;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
//   clk, rst : clock, asynchronous active-high reset
//   start    : EX instruction is a muldiv op (sampled only in IDLE)
//   op       : MULT, MULTU, DIV, DIVU, MTHI, MTLO
//   flush    : squash in-flight op; blocks start in IDLE
//   rd_hilo  : EX instruction reads HI/LO
//   a, b     : rs / rt operands
//   busy     : operation in progress (RUN or FIX)
//   done     : one-cycle pulse, hi/lo hold the new result
//   stall    : busy & (rd_hilo | start)
//   hi, lo   : HI and LO registers
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic             rd_hilo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state, state_n;
  op_e                op_c;
  logic               load, step, wr_fix, wr_hi, wr_lo;
  logic               sgn_op, div_op, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, a_raw_q;
  logic               neg_q_q, neg_r_q, div_q, dz_q;
  logic [2*WIDTH-1:0] result, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [CNT_W-1:0]   count;

  assign op_c   = op_e'(op);
  assign sgn_op = is_signed(op_c);
  assign div_op = is_div(op_c);
  assign a_neg  = sgn_op & a[WIDTH-1];
  assign b_neg  = sgn_op & b[WIDTH-1];
  assign mag_a  = a_neg ? -a : a;
  assign mag_b  = b_neg ? -b : b;

  muldiv_iter_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .div_mode(div_op),
    .op_a    (mag_a),
    .op_b    (mag_b),
    .result  (result),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    wr_fix  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          case (op_c)
            MULT, MULTU: begin
              load    = 1'b1;
              state_n = RUN;
            end
            DIV, DIVU: begin
              load    = 1'b1;
              state_n = (b == '0) ? FIX : RUN;
            end
            MTHI:    wr_hi = 1'b1;
            MTLO:    wr_lo = 1'b1;
            default: state_n = IDLE;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          step = 1'b1;
          if (count == LAST) state_n = FIX;
        end
      end
      FIX: begin
        state_n = IDLE;
        wr_fix  = !flush;
      end
      default: state_n = IDLE;
    endcase
  end

  // Result signs are fixed at capture; the datapath only sees magnitudes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_raw_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (load) begin
      a_raw_q <= a;
      neg_q_q <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r_q <= sgn_op & a[WIDTH-1];
      div_q   <= div_op;
      dz_q    <= div_op && (b == '0);
    end
  end

  always_comb begin
    prod_fix = neg_q_q ? -result : result;
    quo_fix  = neg_q_q ? -result[WIDTH-1:0] : result[WIDTH-1:0];
    rem_fix  = neg_r_q ? -result[2*WIDTH-1:WIDTH] : result[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= wr_fix;
      if (wr_fix) begin
        if (dz_q) begin
          hi <= a_raw_q;
          lo <= '1;
        end else if (div_q) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end else begin
        if (wr_hi) hi <= a;
        if (wr_lo) lo <= a;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (rd_hilo | start);

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, rd_hilo;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, stall;
  int          checks = 0;
  int          errors = 0;

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .rd_hilo(rd_hilo), .a(a), .b(b), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Architectural reference: plain 64-bit / signed-int arithmetic.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] eh, output logic [31:0] el, output int elat);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    elat = 34;
    eh = '0;
    el = '0;
    sx = $signed(x);
    sy = $signed(y);
    if (o == 3'd0) begin
      sp = longint'(sx) * longint'(sy);
      {eh, el} = sp;
    end else if (o == 3'd1) begin
      up = {32'd0, x} * {32'd0, y};
      {eh, el} = up;
    end else if (y == 32'd0) begin
      eh = x;
      el = '1;
      elat = 2;
    end else if (o == 3'd2) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        el = 32'h8000_0000;
        eh = 32'd0;
      end else begin
        el = sx / sy;
        eh = sx % sy;
      end
    end else begin
      el = x / y;
      eh = x % y;
    end
  endfunction

  // Presents one op at the current cycle and waits (bounded) for done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ohi, output logic [31:0] olo, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ohi = hi;
    olo = lo;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, stall, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b stall=%b hi=%h lo=%h want all 0", busy, done, stall, hi, lo);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [6] = '{MULTU, MULT, DIVU, DIV, DIV, DIVU};
    logic [31:0] t_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    logic [31:0] t_b  [6] = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_hi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5};
    logic [31:0] t_lo [6] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    int          t_lat[6] = '{34, 34, 34, 34, 34, 2};
    logic [31:0] oh, ol;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], oh, ol, lat);
      checks++;
      if (lat != t_lat[i] || oh !== t_hi[i] || ol !== t_lo[i]) begin
        errors++;
        $display("FAIL directed_%0d got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                 i, lat, oh, ol, t_lat[i], t_hi[i], t_lo[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse_%0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_mt();
    logic seen = 1'b0;
    op = MTHI; a = 32'h0000_1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen |= done | busy;
    checks++;
    if (hi !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi got hi=%h want 00001234", hi);
    end
    op = MTLO; a = 32'h0000_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen |= done | busy;
    checks++;
    if (lo !== 32'h0000_5678 || hi !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mtlo got hi=%h lo=%h want 00001234 00005678", hi, lo);
    end
    @(posedge clk); #1;
    seen |= done;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mt_no_done got done/busy seen=%b want 0", seen);
    end
  endtask

  task automatic test_flush();
    logic [31:0] h0, l0;
    logic        seen;
    int          c;
    h0 = hi; l0 = lo;
    // flush during RUN
    op = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    seen = 1'b0;
    while (c < 10) begin
      @(posedge clk); #1;
      c++;
      seen |= done;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_run_busy got busy=%b want 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    checks++;
    if (seen !== 1'b0 || hi !== h0 || lo !== l0) begin
      errors++;
      $display("FAIL flush_run_hold got seen=%b hi=%h lo=%h want 0 %h %h", seen, hi, lo, h0, l0);
    end
    // flush during FIX (cycle 33)
    op = MULT; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    seen = 1'b0;
    while (c < 33) begin
      @(posedge clk); #1;
      c++;
      seen |= done;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen |= done;
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0 || hi !== h0 || lo !== l0) begin
      errors++;
      $display("FAIL flush_fix got done_seen=%b busy=%b hi=%h lo=%h want 0 0 %h %h", seen, busy, hi, lo, h0, l0);
    end
    // flush with start in IDLE blocks MTHI and MULT
    flush = 1'b1; start = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    op = MULT;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    checks++;
    if (hi !== h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got hi=%h busy=%b want %h 0", hi, busy, h0);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    op = MTHI; a = 32'hAAAA_5555; start = 1'b1;
    @(posedge clk); #1;
    op = MTLO; a = 32'h1357_9BDF;
    @(posedge clk); #1;
    op = DIV; a = 32'hFFFF_0000; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    checks++;
    if (busy !== 1'b1 || hi !== 32'hAAAA_5555 || lo !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL pre_reset got busy=%b hi=%h lo=%h want 1 aaaa5555 13579bdf", busy, hi, lo);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] x, y, eh, el, h_late;
    int          elat, c, bad;
    x = $urandom; y = $urandom;
    ref_model(3'd0, x, y, eh, el, elat);
    op = MULT; a = x; b = y; rd_hilo = 1'b1; start = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle got %b want 0", stall);
    end
    @(posedge clk); #1;
    c = 1;
    bad = 0;
    while (c <= 33) begin
      start = (c == 5);
      op    = (c == 5) ? MTHI : MULT;
      a     = (c == 5) ? 32'h0000_CAFE : x;
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy_c%0d got %b want 1", c, stall);
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0; op = MULT; a = x;
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b1 || lo !== el || hi !== eh) begin
      errors++;
      $display("FAIL stall_done got stall=%b done=%b hi=%h lo=%h want 0 1 %h %h", stall, done, hi, lo, eh, el);
    end
    rd_hilo = 1'b0;
    @(posedge clk); #1;
    h_late = hi;
    checks++;
    if (h_late !== eh || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored got hi=%h busy=%b want %h 0", h_late, busy, eh);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2, eh1, el1, eh2, el2, oh, ol;
    int          elat1, elat2, lat;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom_range(1, 1000);
    ref_model(3'd1, x1, y1, eh1, el1, elat1);
    ref_model(3'd2, x2, y2, eh2, el2, elat2);
    do_op(MULTU, x1, y1, oh, ol, lat);
    checks++;
    if (lat != elat1 || oh !== eh1 || ol !== el1) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d hi=%h lo=%h want %0d %h %h", lat, oh, ol, elat1, eh1, el1);
    end
    do_op(DIV, x2, y2, oh, ol, lat);
    checks++;
    if (lat != elat2 || oh !== eh2 || ol !== el2) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d hi=%h lo=%h want %0d %h %h", lat, oh, ol, elat2, eh2, el2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, eh, el, oh, ol;
    int          elat, lat;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        default: ;
      endcase
      ref_model(o, x, y, eh, el, elat);
      do_op(o, x, y, oh, ol, lat);
      checks++;
      if (lat != elat || oh !== eh || ol !== el) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h want %0d %h %h",
                 i, o, x, y, lat, oh, ol, elat, eh, el);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; rd_hilo = 1'b0;
    op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_mt();
    test_flush();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
